// File: rtl/pc_branch_unit.sv
// -----------------------------------------------------------------------------
// pc_branch_unit
//
// Program-counter and branch-resolution unit for the single-cycle core. It
// receives the decoder's jump-control fields and the operand and flag data, and
// each cycle it works out the next instruction address.
//
// The unit owns these pieces of architectural state:
//   - the program counter,
//   - the carry flag tested by bcy and bncy,
//   - a "taken" marker for the current pc,
//   - a count of retired instructions.
//
// Parameters
//   ADDR_W    PC / address width in bits (must be >= 28)
//   RESET_PC  PC value loaded by reset
//
// Ports
//   clk          system clock; all state changes on the rising edge
//   rst          synchronous reset, active-high; overrides every other input
//   stall        holds pc, carry flag and counter; clears taken
//   CondJump     000 none, 001 bltz, 010 bz, 011 bnz, 100 bcy, 101 bncy,
//                110/111 reserved (never true)
//   UncondJump   unconditional jump request; wins over CondJump
//   AddrSel      00 pc-relative imm26, 01 register, 10 pc-relative imm16,
//                11 reserved (no target, so the jump is never taken)
//   imm26        instruction immediate; imm16 is imm26[15:0]
//   rs_value     register operand: tested by bltz/bz/bnz, target for br
//   carry_we     ALU result of this instruction updates the carry flag
//   alu_carry    ALU carry-out
//   pc           current program counter (registered)
//   link_addr    pc + 4 (combinational), the return address for bl
//   taken        1 when the current pc was reached by a taken jump
//   carry_flag   architectural carry flag (registered)
//   instr_count  retired instructions: non-stalled, non-reset cycles
// -----------------------------------------------------------------------------
module pc_branch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [2:0]        CondJump,
    input  logic              UncondJump,
    input  logic [1:0]        AddrSel,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_value,
    input  logic              carry_we,
    input  logic              alu_carry,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              taken,
    output logic              carry_flag,
    output logic [31:0]       instr_count
);

    // -------------------------------------------------------------------------
    // Condition codes
    // -------------------------------------------------------------------------
    localparam logic [2:0] COND_NONE = 3'b000;
    localparam logic [2:0] COND_BLTZ = 3'b001;
    localparam logic [2:0] COND_BZ   = 3'b010;
    localparam logic [2:0] COND_BNZ  = 3'b011;
    localparam logic [2:0] COND_BCY  = 3'b100;
    localparam logic [2:0] COND_BNCY = 3'b101;

    // -------------------------------------------------------------------------
    // Target select codes
    // -------------------------------------------------------------------------
    localparam logic [1:0] SEL_REL26 = 2'b00;
    localparam logic [1:0] SEL_REG   = 2'b01;
    localparam logic [1:0] SEL_REL16 = 2'b10;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              taken_q;
    logic              taken_d;
    logic              carry_q;
    logic              carry_d;
    logic [31:0]       count_q;
    logic [31:0]       count_d;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] off26;
    logic [ADDR_W-1:0] off16;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] target;
    logic              target_valid;
    logic              rs_zero;
    logic              cond_true;
    logic              jump_taken;

    // Every target is relative to the sequential address. Additions wrap
    // modulo 2^ADDR_W, which gives the max -> 0 rollover for free.
    assign pc_plus4 = pc_q + ADDR_W'(4);

    // Word offsets: sign-extend the immediate to ADDR_W bits, then scale by 4.
    // ADDR_W >= 28 keeps each replication count positive.
    assign off26 = {{(ADDR_W-26){imm26[25]}}, imm26} << 2;
    assign off16 = {{(ADDR_W-16){imm26[15]}}, imm26[15:0]} << 2;

    // Register targets are forced to word alignment.
    assign reg_target = {rs_value[ADDR_W-1:2], 2'b00};

    assign rs_zero = (rs_value == '0);

    // Condition evaluation. bcy and bncy look at carry_q, the flag value held
    // before this edge. A carry write by the same instruction therefore cannot
    // change the branch decision.
    always_comb begin
        cond_true = 1'b0;
        case (CondJump)
            COND_NONE: cond_true = 1'b0;
            COND_BLTZ: cond_true = rs_value[ADDR_W-1];
            COND_BZ:   cond_true = rs_zero;
            COND_BNZ:  cond_true = ~rs_zero;
            COND_BCY:  cond_true = carry_q;
            COND_BNCY: cond_true = ~carry_q;
            default:   cond_true = 1'b0;  // reserved codes never branch
        endcase
    end

    // Target mux. The reserved select has no target, so it suppresses the jump.
    always_comb begin
        target       = pc_plus4;
        target_valid = 1'b1;
        case (AddrSel)
            SEL_REL26: target = pc_plus4 + off26;
            SEL_REG:   target = reg_target;
            SEL_REL16: target = pc_plus4 + off16;
            default: begin
                target       = pc_plus4;
                target_valid = 1'b0;
            end
        endcase
    end

    assign jump_taken = (UncondJump | cond_true) & target_valid;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // A stalled cycle retires nothing. The pc does not move, so it was not
    // reached by a jump and taken drops to 0.
    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        carry_d = carry_q;
        count_d = count_q;
        if (!stall) begin
            pc_d    = jump_taken ? target : pc_plus4;
            taken_d = jump_taken;
            count_d = count_q + 32'd1;
            if (carry_we) begin
                carry_d = alu_carry;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State update; reset overrides stall and any pending jump
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pc          = pc_q;
    assign link_addr   = pc_plus4;
    assign taken       = taken_q;
    assign carry_flag  = carry_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// -----------------------------------------------------------------------------
// Testbench for pc_branch_unit.
//
// A directed sequence follows the test-plan scenarios and checks them against
// fixed expected values. A randomized phase follows the directed one. A
// behavioural model, written with plain integer arithmetic, tracks pc, carry,
// taken and the retired-instruction count, and every cycle is compared with it.
// -----------------------------------------------------------------------------
module tb_pc_branch_unit;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    // -------------------------------------------------------------------------
    // DUT connections
    // -------------------------------------------------------------------------
    logic        clk;
    logic        rst;
    logic        stall;
    logic [2:0]  CondJump;
    logic        UncondJump;
    logic [1:0]  AddrSel;
    logic [25:0] imm26;
    logic [31:0] rs_value;
    logic        carry_we;
    logic        alu_carry;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        taken;
    logic        carry_flag;
    logic [31:0] instr_count;

    // -------------------------------------------------------------------------
    // Scoreboard counters
    // -------------------------------------------------------------------------
    int checks;
    int failures;

    // -------------------------------------------------------------------------
    // Reference-model state
    // -------------------------------------------------------------------------
    longint      m_pc;
    bit          m_carry;
    bit          m_taken;
    int unsigned m_count;

    pc_branch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .CondJump    (CondJump),
        .UncondJump  (UncondJump),
        .AddrSel     (AddrSel),
        .imm26       (imm26),
        .rs_value    (rs_value),
        .carry_we    (carry_we),
        .alu_carry   (alu_carry),
        .pc          (pc),
        .link_addr   (link_addr),
        .taken       (taken),
        .carry_flag  (carry_flag),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: next state from the architectural rules
    // -------------------------------------------------------------------------
    task automatic model_next(
        input  bit          r,
        input  bit          st,
        input  int          cj,
        input  bit          uj,
        input  int          as,
        input  int          imm,
        input  longint      rs,
        input  bit          cwe,
        input  bit          ac,
        output longint      n_pc,
        output bit          n_carry,
        output bit          n_taken,
        output int unsigned n_count
    );
        longint off;
        longint tgt;
        bit     cond;
        bit     jmp;

        if (r) begin
            n_pc    = longint'(RESET_PC);
            n_carry = 0;
            n_taken = 0;
            n_count = 0;
        end else if (st) begin
            n_pc    = m_pc;
            n_carry = m_carry;
            n_taken = 0;
            n_count = m_count;
        end else begin
            case (cj)
                1:       cond = (rs >= 64'h8000_0000);
                2:       cond = (rs == 0);
                3:       cond = (rs != 0);
                4:       cond = m_carry;
                5:       cond = !m_carry;
                default: cond = 0;
            endcase
            jmp = uj || cond;

            case (as)
                0: begin
                    off = imm;
                    if (off >= (64'sd1 <<< 25)) off = off - (64'sd1 <<< 26);
                    tgt = m_pc + 4 + off * 4;
                end
                1: tgt = (rs / 4) * 4;
                2: begin
                    off = imm % 65536;
                    if (off >= 32768) off = off - 65536;
                    tgt = m_pc + 4 + off * 4;
                end
                default: begin
                    tgt = m_pc + 4;
                    jmp = 0;
                end
            endcase

            n_pc    = (jmp ? tgt : m_pc + 4) & 64'hFFFF_FFFF;
            n_taken = jmp;
            n_carry = cwe ? ac : m_carry;
            n_count = m_count + 1;
        end
    endtask

    // -------------------------------------------------------------------------
    // One clock cycle
    // -------------------------------------------------------------------------
    // Drive the inputs at the falling edge and check link_addr combinationally.
    // Advance the model, then check the DUT state 1 time unit after the rising
    // edge.
    task automatic cycle(
        input bit          r,
        input bit          st,
        input logic [2:0]  cj,
        input bit          uj,
        input logic [1:0]  as,
        input logic [25:0] imm,
        input logic [31:0] rs,
        input bit          cwe,
        input bit          ac
    );
        longint      n_pc;
        bit          n_carry;
        bit          n_taken;
        int unsigned n_count;

        @(negedge clk);
        rst        = r;
        stall      = st;
        CondJump   = cj;
        UncondJump = uj;
        AddrSel    = as;
        imm26      = imm;
        rs_value   = rs;
        carry_we   = cwe;
        alu_carry  = ac;
        #1;
        check_val("link_addr", link_addr, 32'((m_pc + 4) & 64'hFFFF_FFFF));

        model_next(r, st, int'(cj), uj, int'(as), int'(imm), longint'(rs), cwe, ac,
                   n_pc, n_carry, n_taken, n_count);

        @(posedge clk);
        #1;
        m_pc    = n_pc;
        m_carry = n_carry;
        m_taken = n_taken;
        m_count = n_count;
        check_val("pc",          pc,                 32'(m_pc));
        check_val("taken",       {31'b0, taken},     {31'b0, m_taken});
        check_val("carry_flag",  {31'b0, carry_flag}, {31'b0, m_carry});
        check_val("instr_count", instr_count,        m_count);
        $display("cyc rst=%0b st=%0b cj=%0d uj=%0b as=%0d imm=%07h rs=%08h -> pc=%08h tk=%0b cy=%0b cnt=%0d",
                 r, st, cj, uj, as, imm, rs, pc, taken, carry_flag, instr_count);
    endtask

    // Shorthands for the common cycle types.
    task automatic idle();
        cycle(0, 0, 3'd0, 0, 2'd0, 26'd0, 32'd0, 0, 0);
    endtask

    task automatic jump_reg(input logic [31:0] addr);
        cycle(0, 0, 3'd0, 1, 2'd1, 26'd0, addr, 0, 0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        checks     = 0;
        failures   = 0;
        m_pc       = 0;
        m_carry    = 0;
        m_taken    = 0;
        m_count    = 0;
        rst        = 1;
        stall      = 0;
        CondJump   = 0;
        UncondJump = 0;
        AddrSel    = 0;
        imm26      = 0;
        rs_value   = 0;
        carry_we   = 0;
        alu_carry  = 0;

        // Reset state
        cycle(1, 0, 3'd0, 0, 2'd0, 26'd0, 32'd0, 0, 0);
        check_val("rst_pc",  pc,          32'h0);
        check_val("rst_cnt", instr_count, 32'd0);

        // Three sequential steps from reset
        idle();
        idle();
        idle();
        check_val("seq_pc",  pc,              32'd12);
        check_val("seq_cnt", instr_count,     32'd3);
        check_val("seq_tk",  {31'b0, taken},  32'd0);

        // Unconditional jumps: pc-relative negative offset, then register target
        jump_reg(32'h40);
        cycle(0, 0, 3'd0, 1, 2'd0, 26'h3FFFFFE, 32'd0, 0, 0);
        check_val("j26_pc", pc,             32'h3C);
        check_val("j26_tk", {31'b0, taken}, 32'd1);
        cycle(0, 0, 3'd0, 1, 2'd1, 26'd0, 32'h1237, 0, 0);
        check_val("jreg_pc", pc, 32'h1234);

        // bz taken and not taken, then bltz taken
        jump_reg(32'h100);
        cycle(0, 0, 3'd2, 0, 2'd2, 26'h0004, 32'd0, 0, 0);
        check_val("bz_t_pc", pc,             32'h114);
        check_val("bz_t_tk", {31'b0, taken}, 32'd1);
        jump_reg(32'h100);
        cycle(0, 0, 3'd2, 0, 2'd2, 26'h0004, 32'd5, 0, 0);
        check_val("bz_n_pc", pc,             32'h104);
        check_val("bz_n_tk", {31'b0, taken}, 32'd0);
        cycle(0, 0, 3'd1, 0, 2'd2, 26'h0004, 32'h8000_0000, 0, 0);
        check_val("bltz_tk", {31'b0, taken}, 32'd1);

        // Carry set on one instruction, then bcy at pc 0x20
        cycle(0, 0, 3'd0, 1, 2'd1, 26'd0, 32'h1C, 1, 1);
        idle();
        cycle(0, 0, 3'd4, 0, 2'd0, 26'd1, 32'd0, 0, 0);
        check_val("bcy_pc", pc, 32'h28);

        // Same-cycle carry write does not affect the branch: flag cleared
        // first, then bncy with carry_we=1 sees the old 0 and is taken
        cycle(0, 0, 3'd0, 0, 2'd0, 26'd0, 32'd0, 1, 0);
        cycle(0, 0, 3'd5, 0, 2'd0, 26'd1, 32'd0, 1, 1);
        check_val("bncy_tk", {31'b0, taken},      32'd1);
        check_val("bncy_cy", {31'b0, carry_flag}, 32'd1);
        // Flag cleared again, then bcy with carry_we=1 sees the old 0 and falls
        // through
        cycle(0, 0, 3'd0, 0, 2'd0, 26'd0, 32'd0, 1, 0);
        cycle(0, 0, 3'd4, 0, 2'd0, 26'd1, 32'd0, 1, 1);
        check_val("bcy_same_tk", {31'b0, taken}, 32'd0);

        // A reserved target select suppresses an unconditional jump
        cycle(0, 0, 3'd0, 1, 2'd3, 26'd8, 32'h500, 0, 0);
        check_val("sel11_tk", {31'b0, taken}, 32'd0);

        // Two stalled cycles with a pending jump, then release
        cycle(0, 1, 3'd0, 1, 2'd1, 26'd0, 32'h500, 1, 0);
        cycle(0, 1, 3'd0, 1, 2'd1, 26'd0, 32'h500, 1, 0);
        check_val("stall_tk", {31'b0, taken}, 32'd0);
        cycle(0, 0, 3'd0, 1, 2'd1, 26'd0, 32'h500, 0, 0);
        check_val("unstall_pc", pc, 32'h500);

        // pc wraps from the top of the address space to 0
        jump_reg(32'hFFFF_FFFC);
        idle();
        check_val("wrap_pc", pc, 32'h0);

        // Reset wins over a stall and a jump in the same cycle
        cycle(1, 1, 3'd0, 1, 2'd1, 26'd0, 32'h700, 1, 1);
        check_val("rst_jmp_pc",  pc,          RESET_PC);
        check_val("rst_jmp_cnt", instr_count, 32'd0);

        // Randomized phase, checked against the model every cycle
        for (int i = 0; i < 400; i++) begin
            bit          r;
            bit          st;
            logic [31:0] rs;

            r  = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 3))
                0:       rs = 32'd0;
                1:       rs = 32'h8000_0000 | $urandom;
                default: rs = $urandom;
            endcase
            cycle(r, st, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), 26'($urandom), rs,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
